// File: rtl/sb_crc_pkg.sv
// Shared CRC-16 constants and checker state encoding for the serial-bus
// CRC generator/checker pair.
package sb_crc_pkg;

   localparam int               CRC_W    = 16;
   localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
   localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } crc_state_e;

endpackage

// File: rtl/sb_crc16_lfsr.sv
// One-bit step of the CRC-16 (poly 8005h, MSB-first, unreflected) LFSR.
// Purely combinational; the caller owns the register.
module sb_crc16_lfsr
   import sb_crc_pkg::*;
(
   input  logic [CRC_W-1:0] crc_cur,
   input  logic             din,
   output logic [CRC_W-1:0] crc_nxt
);

   logic fb_s;

   assign fb_s    = din ^ crc_cur[CRC_W-1];
   assign crc_nxt = {crc_cur[CRC_W-2:0], 1'b0} ^ (fb_s ? CRC_POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/sb_crc16_chk.sv
// Serial CRC-16 receive checker: folds payload bits into the LFSR, then
// compares the 16 trailing CRC bits MSB-first against the LFSR contents.
module sb_crc16_chk
   import sb_crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED = CRC_SEED
)
(
   input  logic sb_clk,
   input  logic rst,
   input  logic chk_en,
   input  logic rx_valid,
   input  logic rx_bit,
   input  logic crc_active,
   output logic crc_done,
   output logic crc_ok,
   output logic crc_err
);

   crc_state_e       state_r, state_s;
   logic [CRC_W-1:0] lfsr_r, lfsr_s;
   logic [CRC_W-1:0] lfsr_step_s;
   logic [CRC_W-1:0] crc_shift_s;
   logic [3:0]       cnt_r, cnt_s;
   logic             mismatch_r, mismatch_s;
   logic             done_r, done_s;
   logic             ok_r, ok_s;
   logic             err_r, err_s;
   logic             bit_diff_s;

   sb_crc16_lfsr u_lfsr (
      .crc_cur (lfsr_r),
      .din     (rx_bit),
      .crc_nxt (lfsr_step_s)
   );

   // CRC bits just drain the register so lfsr_r[15] always holds the next expected bit
   assign crc_shift_s = {lfsr_r[CRC_W-2:0], 1'b0};
   assign bit_diff_s  = rx_bit ^ lfsr_r[CRC_W-1];

   // Next-state and next-output logic
   always_comb begin
      state_s    = state_r;
      lfsr_s     = lfsr_r;
      cnt_s      = cnt_r;
      mismatch_s = mismatch_r;
      done_s     = 1'b0;
      ok_s       = ok_r;
      err_s      = err_r;
      if (!chk_en) begin
         state_s    = IDLE;
         lfsr_s     = SEED;
         cnt_s      = 4'd0;
         mismatch_s = 1'b0;
         ok_s       = 1'b0;
         err_s      = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               lfsr_s     = SEED;
               cnt_s      = 4'd0;
               mismatch_s = 1'b0;
               ok_s       = 1'b0;
               err_s      = 1'b0;
               state_s    = DATA;
            end
            DATA: begin
               if (rx_valid && crc_active) begin
                  lfsr_s = lfsr_step_s;
               end else if (rx_valid) begin
                  lfsr_s     = crc_shift_s;
                  mismatch_s = mismatch_r | bit_diff_s;
                  cnt_s      = cnt_r + 4'd1;
                  state_s    = CHECK;
               end else begin
                  state_s = DATA;
               end
            end
            CHECK: begin
               // crc_active is deliberately not looked at once the CRC field has begun
               if (rx_valid) begin
                  lfsr_s     = crc_shift_s;
                  mismatch_s = mismatch_r | bit_diff_s;
                  cnt_s      = cnt_r + 4'd1;
                  if (cnt_r == 4'd15) begin
                     state_s = DONE;
                     done_s  = 1'b1;
                     ok_s    = ~(mismatch_r | bit_diff_s);
                     err_s   = mismatch_r | bit_diff_s;
                  end else begin
                     state_s = CHECK;
                  end
               end else begin
                  state_s = CHECK;
               end
            end
            DONE: begin
               state_s = DONE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered output flops
   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         lfsr_r     <= SEED;
         cnt_r      <= 4'd0;
         mismatch_r <= 1'b0;
         done_r     <= 1'b0;
         ok_r       <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         lfsr_r     <= lfsr_s;
         cnt_r      <= cnt_s;
         mismatch_r <= mismatch_s;
         done_r     <= done_s;
         ok_r       <= ok_s;
         err_r      <= err_s;
      end
   end

   assign crc_done = done_r;
   assign crc_ok   = ok_r;
   assign crc_err  = err_r;

endmodule

// File: tb/tb_sb_crc16_chk.sv
// Directed bench for sb_crc16_chk using the CRC-16/CMS check string "123456789".
module tb_sb_crc16_chk;

   logic sb_clk;
   logic rst;
   logic chk_en;
   logic rx_valid;
   logic rx_bit;
   logic crc_active;
   logic crc_done;
   logic crc_ok;
   logic crc_err;

   int tests_run;
   int tests_failed;
   int done_cnt;
   int excl_cnt;

   localparam logic [71:0] MSG      = 72'h31_32_33_34_35_36_37_38_39;
   localparam logic [15:0] CRC_GOOD = 16'hAEE7;
   localparam logic [15:0] CRC_BAD  = 16'hAEE6;

   sb_crc16_chk #(.SEED(16'hFFFF)) dut (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .chk_en     (chk_en),
      .rx_valid   (rx_valid),
      .rx_bit     (rx_bit),
      .crc_active (crc_active),
      .crc_done   (crc_done),
      .crc_ok     (crc_ok),
      .crc_err    (crc_err)
   );

   initial sb_clk = 1'b0;
   always #5 sb_clk = ~sb_clk;

   // Count done pulses and any cycle with ok and err both set
   always @(posedge sb_clk) begin
      if (crc_done === 1'b1) done_cnt <= done_cnt + 1;
      if (crc_ok === 1'b1 && crc_err === 1'b1) excl_cnt <= excl_cnt + 1;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sb_clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input logic act);
      rx_valid   = 1'b1;
      rx_bit     = b;
      crc_active = act;
      @(posedge sb_clk);
      #1;
      rx_valid   = 1'b0;
      rx_bit     = 1'b0;
      crc_active = 1'b0;
   endtask

   task automatic start_frame();
      chk_en = 1'b1;
      idle(1);
   endtask

   task automatic send_frame(input logic [71:0] data, input int nbits, input logic [15:0] crc,
                             input bit gaps, input bit act_in_check);
      for (int i = nbits - 1; i >= 0; i--) begin
         send_bit(data[i], 1'b1);
         if (gaps) idle(int'($urandom_range(0, 3)));
      end
      for (int i = 15; i >= 0; i--) begin
         send_bit(crc[i], (act_in_check && i != 15) ? 1'b1 : 1'b0);
         if (gaps && i != 0) idle(int'($urandom_range(0, 3)));
      end
   endtask

   task automatic end_frame();
      chk_en = 1'b0;
      idle(1);
   endtask

   task automatic test_reset();
      rst = 1'b0; chk_en = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; crc_active = 1'b0;
      done_cnt = 0; excl_cnt = 0;
      idle(3);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got done/ok/err=%b expected 000", {crc_done, crc_ok, crc_err});
      end
      rst = 1'b1;
      idle(2);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL idle_outputs: got done/ok/err=%b expected 000", {crc_done, crc_ok, crc_err});
      end
   endtask

   task automatic test_good_frame();
      int d0;
      d0 = done_cnt;
      start_frame();
      send_frame(MSG, 72, CRC_GOOD, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL good_result: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      idle(1);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b010) begin
         tests_failed++;
         $display("FAIL good_hold: got done/ok/err=%b expected 010", {crc_done, crc_ok, crc_err});
      end
      tests_run++;
      if (done_cnt - d0 !== 1) begin
         tests_failed++;
         $display("FAIL good_pulses: got %0d expected 1", done_cnt - d0);
      end
      end_frame();
      tests_run++;
      if ({crc_ok, crc_err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL disable_clears: got ok/err=%b expected 00", {crc_ok, crc_err});
      end
   endtask

   task automatic test_bad_frame();
      start_frame();
      send_frame(MSG, 72, CRC_BAD, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b101) begin
         tests_failed++;
         $display("FAIL bad_result: got done/ok/err=%b expected 101", {crc_done, crc_ok, crc_err});
      end
      end_frame();
   endtask

   task automatic test_back_to_back();
      start_frame();
      send_frame(MSG, 72, CRC_GOOD, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL b2b_after_bad: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      end_frame();
   endtask

   task automatic test_short_frames();
      start_frame();
      send_frame(72'h0, 1, 16'h7FFB, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL one_bit_payload: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      end_frame();
      start_frame();
      send_frame(72'h0, 0, 16'hFFFF, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL zero_payload: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      end_frame();
      start_frame();
      send_frame(72'h0, 0, 16'hFFFE, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b101) begin
         tests_failed++;
         $display("FAIL zero_payload_bad: got done/ok/err=%b expected 101", {crc_done, crc_ok, crc_err});
      end
      end_frame();
   endtask

   task automatic test_gaps();
      int d0;
      d0 = done_cnt;
      start_frame();
      send_frame(MSG, 72, CRC_GOOD, 1'b1, 1'b1);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL gaps_result: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      for (int i = 0; i < 6; i++) send_bit(i[0], i[1]);
      idle(2);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b010) begin
         tests_failed++;
         $display("FAIL gaps_after_done: got done/ok/err=%b expected 010", {crc_done, crc_ok, crc_err});
      end
      tests_run++;
      if (done_cnt - d0 !== 1) begin
         tests_failed++;
         $display("FAIL gaps_pulses: got %0d expected 1", done_cnt - d0);
      end
      end_frame();
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_cnt;
      start_frame();
      for (int i = 71; i >= 32; i--) send_bit(MSG[i], 1'b1);
      chk_en = 1'b0;
      idle(1);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL abort_outputs: got done/ok/err=%b expected 000", {crc_done, crc_ok, crc_err});
      end
      for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b0);
      idle(2);
      tests_run++;
      if (done_cnt - d0 !== 0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0);
      end
      start_frame();
      send_frame(MSG, 72, CRC_GOOD, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL after_abort: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      end_frame();
   endtask

   task automatic test_reset_mid();
      start_frame();
      for (int i = 71; i >= 0; i--) send_bit(MSG[i], 1'b1);
      for (int i = 15; i >= 8; i--) send_bit(CRC_GOOD[i], 1'b0);
      #2;
      rst    = 1'b0;
      chk_en = 1'b0;
      #1;
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_in_check: got done/ok/err=%b expected 000", {crc_done, crc_ok, crc_err});
      end
      idle(2);
      rst = 1'b1;
      idle(1);
      start_frame();
      send_frame(MSG, 72, CRC_GOOD, 1'b0, 1'b0);
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL after_reset: got done/ok/err=%b expected 110", {crc_done, crc_ok, crc_err});
      end
      idle(1);
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if ({crc_done, crc_ok, crc_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL async_reset_done: got done/ok/err=%b expected 000", {crc_done, crc_ok, crc_err});
      end
      chk_en = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
      tests_run++;
      if (excl_cnt !== 0) begin
         tests_failed++;
         $display("FAIL ok_err_exclusive: got %0d overlapping cycles expected 0", excl_cnt);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_back_to_back();
      test_short_frames();
      test_gaps();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sb_crc16_chk.md
SB_CRC16_CHK -- requirements
Module: sb_crc16_chk

Interface
REQ-001 SHALL have parameter SEED, default 16'hFFFF, initial LFSR value.
REQ-002 SHALL have port sb_clk  input  1  operating clock; the block uses this single clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port chk_en  input  1  frame enable: high for the whole received transaction, low between frames.
REQ-005 SHALL have port rx_valid  input  1  qualifies rx_bit for one cycle.
REQ-006 SHALL have port rx_bit  input  1  received serial bit, MSB-first.
REQ-007 SHALL have port crc_active  input  1  high = payload bit, low = CRC bit; sampled only with rx_valid.
REQ-008 SHALL have port crc_done  output  1  one-cycle pulse when the check completes.
REQ-009 SHALL have port crc_ok  output  1  level: received CRC matched.
REQ-010 SHALL have port crc_err  output  1  level: received CRC mismatched.

Function
REQ-011 SHALL implement CRC-16 with polynomial 8005h, no reflection, no final XOR: fb = rx_bit ^ lfsr[15]; next = {lfsr[14:0],0} ^ (fb ? 16'h8005 : 0).
REQ-012 SHALL use states IDLE, DATA, CHECK, DONE.
REQ-013 IDLE: lfsr = SEED, cnt = 0, mismatch = 0; go to DATA when chk_en = 1.
REQ-014 DATA: rx_valid & crc_active -> LFSR update per REQ-011.
REQ-015 DATA: rx_valid & !crc_active -> the bit is CRC bit 0; go to CHECK.
REQ-016 CRC bit handling: compare rx_bit with lfsr[15], OR any difference into sticky mismatch, shift lfsr left filling 0, increment 4-bit cnt.
REQ-017 CHECK: each rx_valid bit is handled per REQ-016 whatever crc_active is; crc_active = 1 in CHECK is ignored.
REQ-018 The 16th CRC bit (cnt = 15) SHALL move the FSM to DONE.
REQ-019 On the cycle after the 16th CRC bit is sampled, crc_done = 1 for exactly one cycle; crc_ok = !mismatch_final and crc_err = mismatch_final become valid in that same cycle (latency 1).
REQ-020 DONE: crc_ok/crc_err hold; further rx_valid bits are ignored; crc_done does not re-pulse.
REQ-021 chk_en = 0 in any state -> IDLE next cycle; crc_ok, crc_err, lfsr, cnt and mismatch clear.
REQ-022 chk_en = 0 mid-frame aborts silently: no crc_done.
REQ-023 rx_valid = 0 SHALL hold all state (gaps allowed anywhere).
REQ-024 Zero payload bits (first valid bit has crc_active = 0) is legal; expected CRC = SEED.
REQ-025 crc_ok and crc_err SHALL never both be 1.

Reset
REQ-026 rst = 0 SHALL asynchronously force IDLE, lfsr = SEED, cnt = 0, mismatch = 0, crc_done = 0, crc_ok = 0, crc_err = 0; reset mid-frame discards the frame.

Structure
REQ-027 Package sb_crc_pkg SHALL hold CRC_W = 16, CRC_POLY = 16'h8005, CRC_SEED = 16'hFFFF and the FSM state enum; the transmit-side generator shares the same constants.
REQ-028 Sub-module sb_crc16_lfsr (one-bit LFSR step, combinational) SHALL be instantiated for REQ-011; FSM, counter and compare stay in the top.

Verification
REQ-029 ASCII "123456789" (72 bits, MSB-first) plus CRC AEE7h -> crc_done pulse 1 cycle after the last bit, crc_ok = 1, crc_err = 0.
REQ-030 Same payload plus CRC AEE6h (last bit flipped) -> crc_done, crc_err = 1, crc_ok = 0.
REQ-031 Single payload bit 0 plus CRC 7FFBh -> crc_ok = 1; zero payload bits plus CRC FFFFh -> crc_ok = 1.
REQ-032 Vector of REQ-029 with random rx_valid gaps and extra bits after DONE -> identical result, single crc_done.
REQ-033 chk_en dropped after 40 payload bits -> no crc_done, IDLE next cycle; the next frame per REQ-029 passes.
REQ-034 rst asserted during the CHECK phase -> all outputs 0 immediately; the following frame passes.
